// File: rtl/windowed_rf_pkg.sv
// Shared constants, types and address translation
// for the windowed register file.
package windowed_rf_pkg;

    localparam int NGLOBALS = 8;
    localparam int WIN_REGS = 16;
    localparam int ARCH_W   = 5;
    localparam int PHYS_W   = 10;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_SAVE,
        REQ_RESTORE,
        REQ_LOAD
    } win_req_e;

    typedef struct packed {
        logic [ARCH_W-1:0] cwp;
        logic              ovf;
        logic              unf;
    } win_ctl_t;

    // Globals occupy physical 0..7; windowed words follow.
    // cwp < nwin, so one conditional subtract is enough for the wrap.
    function automatic logic [PHYS_W-1:0] xlate_addr(
        input logic [ARCH_W-1:0] arch,
        input logic [ARCH_W-1:0] cwp,
        input int                nwin
    );
        logic [PHYS_W-1:0] span;
        logic [PHYS_W-1:0] w;
        span = PHYS_W'(nwin * WIN_REGS);
        w = PHYS_W'(cwp) * PHYS_W'(WIN_REGS)
          + PHYS_W'(arch) - PHYS_W'(NGLOBALS);
        if (w >= span) begin
            w = w - span;
        end
        if (arch < ARCH_W'(NGLOBALS)) begin
            return PHYS_W'(arch);
        end
        return PHYS_W'(NGLOBALS) + w;
    endfunction

endpackage

// File: rtl/rf_addr_xlate.sv
// Combinational architectural-to-physical
// register index translation.
module rf_addr_xlate
    import windowed_rf_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int IDX_W    = 8
) (
    input  logic [ARCH_W-1:0] arch,
    input  logic [ARCH_W-1:0] cwp,
    output logic [IDX_W-1:0]  phys
);

    assign phys = IDX_W'(xlate_addr(arch, cwp, NWINDOWS));

endmodule

// File: rtl/windowed_reg_file.sv
// Register file with SPARC-style overlapping windows,
// CWP/WIM control and overflow/underflow trap pulses.
module windowed_reg_file
    import windowed_rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NWINDOWS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    output logic [DATA_W-1:0]   rs1_data,
    output logic [DATA_W-1:0]   rs2_data,
    input  logic                we,
    input  logic [4:0]          rd_addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                save,
    input  logic                restore,
    input  logic                cwp_we,
    input  logic [4:0]          cwp_wdata,
    input  logic                wim_we,
    input  logic [NWINDOWS-1:0] wim_wdata,
    output logic [4:0]          cwp,
    output logic [NWINDOWS-1:0] wim,
    output logic                win_ovf,
    output logic                win_unf
);

    localparam int NPHYS = NGLOBALS + NWINDOWS * WIN_REGS;
    localparam int IDX_W = $clog2(NPHYS);
    localparam logic [5:0] NWIN6 = 6'(NWINDOWS);
    localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);

    logic [DATA_W-1:0] mem [NPHYS];

    logic [IDX_W-1:0] rs1_idx;
    logic [IDX_W-1:0] rs2_idx;
    logic [IDX_W-1:0] rd_idx;

    logic              wr_en;
    logic [DATA_W-1:0] rs1_next;
    logic [DATA_W-1:0] rs2_next;

    win_req_e          req;
    win_ctl_t          nxt;
    logic [4:0]        cwp_dec;
    logic [4:0]        cwp_inc;
    logic              dec_hit;
    logic              inc_hit;

    rf_addr_xlate #(
        .NWINDOWS(NWINDOWS),
        .IDX_W   (IDX_W)
    ) u_xlate_rs1 (
        .arch(rs1_addr),
        .cwp (cwp),
        .phys(rs1_idx)
    );

    rf_addr_xlate #(
        .NWINDOWS(NWINDOWS),
        .IDX_W   (IDX_W)
    ) u_xlate_rs2 (
        .arch(rs2_addr),
        .cwp (cwp),
        .phys(rs2_idx)
    );

    rf_addr_xlate #(
        .NWINDOWS(NWINDOWS),
        .IDX_W   (IDX_W)
    ) u_xlate_rd (
        .arch(rd_addr),
        .cwp (cwp),
        .phys(rd_idx)
    );

    // r0 is never stored; writes during reset are dropped.
    assign wr_en = we && (rd_addr != 5'd0) && !rst;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[rd_idx] <= wdata;
        end
    end

    // Compare physical indices so aliased in/out names bypass too.
    always_comb begin
        rs1_next = mem[rs1_idx];
        rs2_next = mem[rs2_idx];
        if (wr_en && (rd_idx == rs1_idx)) begin
            rs1_next = wdata;
        end
        if (wr_en && (rd_idx == rs2_idx)) begin
            rs2_next = wdata;
        end
        if (rs1_addr == 5'd0) begin
            rs1_next = '0;
        end
        if (rs2_addr == 5'd0) begin
            rs2_next = '0;
        end
    end

    always_comb begin
        req = REQ_NONE;
        if (cwp_we) begin
            req = REQ_LOAD;
        end else if (save && !restore) begin
            req = REQ_SAVE;
        end else if (restore && !save) begin
            req = REQ_RESTORE;
        end
    end

    assign cwp_dec = (cwp == 5'd0) ? CWP_MAX : cwp - 5'd1;
    assign cwp_inc = (cwp == CWP_MAX) ? 5'd0 : cwp + 5'd1;
    assign dec_hit = |(wim & (NWINDOWS'(1) << cwp_dec));
    assign inc_hit = |(wim & (NWINDOWS'(1) << cwp_inc));

    always_comb begin
        nxt.cwp = cwp;
        nxt.ovf = 1'b0;
        nxt.unf = 1'b0;
        unique case (req)
            REQ_LOAD: begin
                if ({1'b0, cwp_wdata} < NWIN6) begin
                    nxt.cwp = cwp_wdata;
                end
            end
            REQ_SAVE: begin
                if (dec_hit) begin
                    nxt.ovf = 1'b1;
                end else begin
                    nxt.cwp = cwp_dec;
                end
            end
            REQ_RESTORE: begin
                if (inc_hit) begin
                    nxt.unf = 1'b1;
                end else begin
                    nxt.cwp = cwp_inc;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cwp      <= '0;
            wim      <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            win_ovf  <= 1'b0;
            win_unf  <= 1'b0;
        end else begin
            cwp      <= nxt.cwp;
            win_ovf  <= nxt.ovf;
            win_unf  <= nxt.unf;
            rs1_data <= rs1_next;
            rs2_data <= rs2_next;
            if (wim_we) begin
                wim <= wim_wdata;
            end
        end
    end

endmodule

// File: tb/tb_windowed_reg_file.sv
// Randomized self-checking bench for windowed_reg_file
// against an array-based model of the window rules.
module tb_windowed_reg_file;

    localparam int DW   = 32;
    localparam int NW   = 8;
    localparam int NWIN = NW * 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic          we;
    logic [4:0]    rd_addr;
    logic [DW-1:0] wdata;
    logic          save;
    logic          restore;
    logic          cwp_we;
    logic [4:0]    cwp_wdata;
    logic          wim_we;
    logic [NW-1:0] wim_wdata;
    logic [4:0]    cwp;
    logic [NW-1:0] wim;
    logic          win_ovf;
    logic          win_unf;

    windowed_reg_file #(
        .DATA_W  (DW),
        .NWINDOWS(NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (we),
        .rd_addr  (rd_addr),
        .wdata    (wdata),
        .save     (save),
        .restore  (restore),
        .cwp_we   (cwp_we),
        .cwp_wdata(cwp_wdata),
        .wim_we   (wim_we),
        .wim_wdata(wim_wdata),
        .cwp      (cwp),
        .wim      (wim),
        .win_ovf  (win_ovf),
        .win_unf  (win_unf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_glb [8];
    logic [DW-1:0] m_win [NWIN];
    int            m_cwp;
    logic [NW-1:0] m_wim;
    logic [DW-1:0] e_rs1;
    logic [DW-1:0] e_rs2;
    logic          e_ovf;
    logic          e_unf;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int win_slot(int r);
        return (m_cwp * 16 + r - 8) % NWIN;
    endfunction

    function automatic logic [DW-1:0] m_read(int r);
        if (r == 0) return '0;
        if (r < 8) return m_glb[r];
        return m_win[win_slot(r)];
    endfunction

    task automatic m_write(int r, logic [DW-1:0] d);
        if (r == 0) return;
        if (r < 8) m_glb[r] = d;
        else m_win[win_slot(r)] = d;
    endtask

    task automatic idle();
        rs1_addr  = '0;
        rs2_addr  = '0;
        we        = 1'b0;
        rd_addr   = '0;
        wdata     = '0;
        save      = 1'b0;
        restore   = 1'b0;
        cwp_we    = 1'b0;
        cwp_wdata = '0;
        wim_we    = 1'b0;
        wim_wdata = '0;
    endtask

    task automatic m_reset();
        m_cwp = 0;
        m_wim = '0;
        e_rs1 = '0;
        e_rs2 = '0;
        e_ovf = 1'b0;
        e_unf = 1'b0;
    endtask

    task automatic check_outs(string tag);
        check({tag, ".rs1"}, rs1_data, e_rs1);
        check({tag, ".rs2"}, rs2_data, e_rs2);
        check({tag, ".cwp"}, cwp, m_cwp);
        check({tag, ".wim"}, wim, m_wim);
        check({tag, ".ovf"}, win_ovf, e_ovf);
        check({tag, ".unf"}, win_unf, e_unf);
    endtask

    // Write lands first, then reads see the updated storage.
    task automatic cycle(string tag);
        int n;
        if (we) m_write(int'(rd_addr), wdata);
        e_rs1 = m_read(int'(rs1_addr));
        e_rs2 = m_read(int'(rs2_addr));
        e_ovf = 1'b0;
        e_unf = 1'b0;
        if (cwp_we) begin
            if (int'(cwp_wdata) < NW) m_cwp = int'(cwp_wdata);
        end else if (save && !restore) begin
            n = (m_cwp + NW - 1) % NW;
            if (m_wim[n]) e_ovf = 1'b1;
            else m_cwp = n;
        end else if (restore && !save) begin
            n = (m_cwp + 1) % NW;
            if (m_wim[n]) e_unf = 1'b1;
            else m_cwp = n;
        end
        if (wim_we) m_wim = wim_wdata;
        @(posedge clk);
        #1;
        check_outs(tag);
        idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        m_reset();
        #1 rst = 1'b1;
        #1 check_outs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < NW; w++) begin
            cwp_we = 1'b1;
            cwp_wdata = 5'(w);
            cycle("init_cwp");
            for (int r = 8; r < 24; r++) begin
                we = 1'b1;
                rd_addr = 5'(r);
                wdata = $urandom;
                cycle("init_win");
            end
        end
        for (int r = 1; r < 8; r++) begin
            we = 1'b1;
            rd_addr = 5'(r);
            wdata = $urandom;
            cycle("init_glb");
        end
        cwp_we = 1'b1;
        cwp_wdata = 5'd0;
        cycle("cwp0");

        we = 1'b1; rd_addr = 5'd1; wdata = 32'hDEADBEEF;
        cycle("wr_r1");
        rs1_addr = 5'd1;
        cycle("rd_r1");
        check("r1_value", rs1_data, 32'hDEADBEEF);
        we = 1'b1; rd_addr = 5'd0; wdata = 32'h1234; rs1_addr = 5'd0;
        cycle("wr_r0");
        rs1_addr = 5'd0;
        cycle("rd_r0");
        check("r0_zero", rs1_data, 0);

        we = 1'b1; rd_addr = 5'd8; wdata = 32'hA5A50001;
        cycle("wr_r8");
        save = 1'b1;
        cycle("save_wrap");
        check("cwp_wrap7", cwp, 7);
        rs1_addr = 5'd24;
        cycle("rd_r24");
        check("alias_r24", rs1_data, 32'hA5A50001);
        restore = 1'b1;
        cycle("restore_wrap");
        check("cwp_back0", cwp, 0);
        rs1_addr = 5'd8;
        cycle("rd_r8");
        check("r8_kept", rs1_data, 32'hA5A50001);

        wim_we = 1'b1; wim_wdata = 8'h80;
        cycle("wim80");
        save = 1'b1;
        cycle("ovf");
        check("ovf_pulse", win_ovf, 1);
        check("ovf_cwp", cwp, 0);
        cycle("ovf_end");
        check("ovf_once", win_ovf, 0);
        wim_we = 1'b1; wim_wdata = 8'h02;
        cycle("wim02");
        restore = 1'b1;
        cycle("unf");
        check("unf_pulse", win_unf, 1);
        check("unf_cwp", cwp, 0);
        wim_we = 1'b1; wim_wdata = 8'h00;
        cycle("wim00");

        we = 1'b1; rd_addr = 5'd16; wdata = 32'h55; rs2_addr = 5'd16;
        cycle("bypass");
        check("bypass_rs2", rs2_data, 32'h55);
        save = 1'b1; restore = 1'b1;
        cycle("save_restore");
        check("sr_noop_cwp", cwp, 0);
        check("sr_no_trap", {win_ovf, win_unf}, 0);

        cwp_we = 1'b1; cwp_wdata = 5'd9;
        cycle("cwp_bad");
        check("cwp_ignored", cwp, 0);
        cwp_we = 1'b1; cwp_wdata = 5'd3; save = 1'b1;
        cycle("cwp_load");
        check("cwp_load3", cwp, 3);

        cwp_we = 1'b1; cwp_wdata = 5'd5;
        cycle("cwp5");
        save = 1'b1;
        #3 rst = 1'b1;
        m_reset();
        #1 check_outs("async_rst");
        @(posedge clk);
        #1 check_outs("rst_hold");
        #3;
        rst = 1'b0;
        save = 1'b0;
        cycle("post_rst");
        check("post_rst_cwp", cwp, 0);

        for (int i = 0; i < 1500; i++) begin
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            rd_addr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            if ($urandom_range(0, 3) == 0) rs2_addr = rd_addr;
            case ($urandom_range(0, 9))
                0, 1, 2: save = 1'b1;
                3, 4, 5: restore = 1'b1;
                6: begin save = 1'b1; restore = 1'b1; end
                7: begin
                    cwp_we = 1'b1;
                    cwp_wdata = 5'($urandom_range(0, 15));
                    save = 1'($urandom_range(0, 1));
                end
                8: begin
                    wim_we = 1'b1;
                    wim_wdata = NW'($urandom & $urandom & $urandom);
                    save = 1'($urandom_range(0, 1));
                    restore = !save;
                end
                default: ;
            endcase
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
